inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 130 +++++++++++++
 tb/tb_inst_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode.
// Fetch pushes up to FETCH_W words per cycle; decode sees the oldest ISSUE_W
// entries and pops up to ISSUE_W per cycle. Optional macro
// INST_QUEUE_BYPASS_EN lets an empty queue forward fetched words straight to
// Iout in the same cycle; without it, a written word first shows up on Iout
// one cycle after the write.
module inst_queue #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [32*FETCH_W-1:0]           Iin,
  input  logic [FETCH_W-1:0]              Iin_valid,
  output logic [$clog2(FETCH_W+1)-1:0]    in_count,
  output logic [32*ISSUE_W-1:0]           Iout,
  output logic [ISSUE_W-1:0]              Iout_valid,
  input  logic [$clog2(ISSUE_W+1)-1:0]    out_read_count,
  output logic [$clog2(DEPTH+1)-1:0]      empty_count,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

  localparam int CIW = $clog2(FETCH_W+1);
  localparam int OCW = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);

  logic [31:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [OCW-1:0] r_occ;

  logic [CIW-1:0] w_lead;
  logic           w_run;
  logic [CIW-1:0] w_in_count;
  logic [OCW-1:0] w_free;
  logic [OCW-1:0] w_avail;
  logic [OCW-1:0] w_req;
  logic [OCW-1:0] w_pop;
  logic           w_byp;

  // Free space is taken from the registered occupancy only, so a same-cycle
  // pop never opens room for fetch (no decode-to-fetch combinational path).
  assign w_free      = OCW'(DEPTH) - r_occ;
  assign empty_count = w_free;
  assign occupancy   = r_occ;

  // Count contiguous valid slots starting at slot 0; a hole ends the run.
  always_comb begin
    w_lead = '0;
    w_run  = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (w_run && Iin_valid[i]) begin
        w_lead = w_lead + CIW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Accept the valid run, clipped to free space; nothing during reset or flush.
  always_comb begin
    w_in_count = '0;
    if (reset && !flush) begin
      if (OCW'(w_lead) > w_free) begin
        w_in_count = CIW'(w_free);
      end else begin
        w_in_count = w_lead;
      end
    end
  end

  assign in_count = w_in_count;

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue: fetched words are visible (and poppable) this same cycle.
  assign w_byp = reset && !flush && (r_occ == '0);
`else
  assign w_byp = 1'b0;
`endif

  // Entries visible to decode this cycle, and the clipped pop count.
  assign w_avail = w_byp ? OCW'(w_in_count) : r_occ;
  assign w_req   = OCW'(out_read_count);
  assign w_pop   = (w_req < w_avail) ? w_req : w_avail;

  // Issue window: slot k shows entry head+k (or fetch slot k when bypassing).
  generate
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_issue
      logic [PW-1:0] w_rd_idx;
      logic [31:0]   w_word;
      assign w_rd_idx = r_head + PW'(gi);
      if (gi < FETCH_W) begin : g_byp
        assign w_word = w_byp ? Iin[32*gi +: 32] : r_mem[w_rd_idx];
      end else begin : g_nobyp
        assign w_word = r_mem[w_rd_idx];
      end
      assign Iout_valid[gi]      = reset && (OCW'(gi) < w_avail);
      assign Iout[32*gi +: 32]   = Iout_valid[gi] ? w_word : 32'd0;
    end
  endgenerate

  // Storage write: accepted slots land at tail, tail+1, ... in slot order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (CIW'(i) < w_in_count) begin
        r_mem[r_tail + PW'(i)] <= Iin[32*i +: 32];
      end
    end
  end

  // Pointer/occupancy update; reset dominates flush, both empty the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PW'(w_pop);
      r_tail <= r_tail + PW'(w_in_count);
      r_occ  <= r_occ + OCW'(w_in_count) - w_pop;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed table plus hand sequences for inst_queue
// (DEPTH=16, FETCH_W=4, ISSUE_W=4). A word queue tracks what decode must see.
module tb_inst_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [127:0] Iin;
  logic [3:0]   Iin_valid;
  logic [2:0]   in_count;
  logic [127:0] Iout;
  logic [3:0]   Iout_valid;
  logic [2:0]   out_read_count;
  logic [4:0]   empty_count;
  logic [4:0]   occupancy;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];
  logic [31:0] next_word;

  typedef struct {
    logic [3:0] v;
    int         rd;
    logic       fl;
    int         exp_in;
    int         exp_occ;
    logic [3:0] exp_iv;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16), .FETCH_W(4), .ISSUE_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .Iin(Iin),
    .Iin_valid(Iin_valid),
    .in_count(in_count),
    .Iout(Iout),
    .Iout_valid(Iout_valid),
    .out_read_count(out_read_count),
    .empty_count(empty_count),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive, check combinational outputs against the word queue,
  // update the queue, then advance to 1 time unit after the next edge.
  task automatic step(input logic [3:0] v, input int rd, input logic fl, input int exp_in);
    int avail;
    int npop;
    logic [3:0] exp_iv;
    Iin_valid      = v;
    out_read_count = 3'(rd);
    flush          = fl;
    for (int s = 0; s < 4; s++) Iin[32*s +: 32] = next_word + 32'(s);
    #1;
    chk("in_count", 32'(in_count), 32'(exp_in));
    avail = q.size();
`ifdef INST_QUEUE_BYPASS_EN
    if (avail == 0 && !fl) avail = exp_in;
`endif
    if (!fl) for (int s = 0; s < exp_in; s++) q.push_back(next_word + 32'(s));
    exp_iv = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (k < avail) begin
        exp_iv[k] = 1'b1;
        chk($sformatf("iout[%0d]", k), Iout[32*k +: 32], q[k]);
      end else begin
        chk($sformatf("iout_zero[%0d]", k), Iout[32*k +: 32], 32'd0);
      end
    end
    chk("iout_valid", 32'(Iout_valid), 32'(exp_iv));
    npop = (rd < avail) ? rd : avail;
    if (fl) q.delete();
    else repeat (npop) void'(q.pop_front());
    next_word = next_word + 32'(exp_in);
    $display("step v=%b rd=%0d flush=%0d in_count=%0d iout_valid=%b model_occ=%0d",
             v, rd, fl, in_count, Iout_valid, q.size());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int ein;
    reset          = 1'b0;
    flush          = 1'b0;
    Iin_valid      = 4'b1111;
    out_read_count = 3'd0;
    Iin            = {32'h4, 32'h3, 32'h2, 32'h1};
    next_word      = 32'hC0DE_0000;

    // Reset state, with fetch offering four valid words.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_count", 32'(in_count), 32'd0);
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_empty", 32'(empty_count), 32'd16);
    chk("reset_iout_valid", 32'(Iout_valid), 32'd0);
    chk("reset_iout_zero", 32'(Iout != 128'd0), 32'd0);
    $display("reset checked occ=%0d empty=%0d", occupancy, empty_count);
    reset     = 1'b1;
    Iin_valid = 4'b0000;

    tbl[0]  = '{4'b1111, 0, 1'b0, 4,  4, 4'b1111};
    tbl[1]  = '{4'b1101, 0, 1'b0, 1,  5, 4'b1111};
    tbl[2]  = '{4'b1110, 0, 1'b0, 0,  5, 4'b1111};
    tbl[3]  = '{4'b1111, 2, 1'b0, 4,  7, 4'b1111};
    tbl[4]  = '{4'b1111, 0, 1'b0, 4, 11, 4'b1111};
    tbl[5]  = '{4'b0111, 0, 1'b0, 3, 14, 4'b1111};
    tbl[6]  = '{4'b1111, 4, 1'b0, 2, 12, 4'b1111};
    tbl[7]  = '{4'b1111, 0, 1'b0, 4, 16, 4'b1111};
    tbl[8]  = '{4'b1111, 0, 1'b0, 0, 16, 4'b1111};
    tbl[9]  = '{4'b0000, 4, 1'b0, 0, 12, 4'b1111};
    tbl[10] = '{4'b0011, 3, 1'b0, 2, 11, 4'b1111};
    tbl[11] = '{4'b0000, 2, 1'b0, 0,  9, 4'b1111};
    tbl[12] = '{4'b1111, 2, 1'b1, 0,  0, 4'b0000};
    tbl[13] = '{4'b0000, 4, 1'b0, 0,  0, 4'b0000};
    tbl[14] = '{4'b0001, 0, 1'b0, 1,  1, 4'b0001};
    tbl[15] = '{4'b0000, 4, 1'b0, 0,  0, 4'b0000};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].rd, tbl[i].fl, tbl[i].exp_in);
      chk($sformatf("occ_after[%0d]", i), 32'(occupancy), 32'(tbl[i].exp_occ));
      chk($sformatf("empty_after[%0d]", i), 32'(empty_count), 32'(16 - tbl[i].exp_occ));
      chk($sformatf("iv_after[%0d]", i), 32'(Iout_valid), 32'(tbl[i].exp_iv));
    end

    // Empty queue, push 4 and pop 2 in the same cycle.
    step(4'b1111, 2, 1'b0, 4);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_occ", 32'(occupancy), 32'd2);
`else
    chk("byp_occ", 32'(occupancy), 32'd4);
`endif
    step(4'b0000, 0, 1'b1, 0);
    chk("flush_occ", 32'(occupancy), 32'd0);

    // Sustained push 3 / pop 2 with pointer wrap; order checked via Iout.
    for (int c = 0; c < 40; c++) begin
      e   = 16 - q.size();
      ein = (e < 3) ? e : 3;
      step(4'b0111, 2, 1'b0, ein);
      chk($sformatf("wrap_occ[%0d]", c), 32'(occupancy), 32'(q.size()));
    end

    // Reset in the middle of operation discards everything.
    reset          = 1'b0;
    Iin_valid      = 4'b1111;
    out_read_count = 3'd1;
    #1;
    chk("midrst_in_count", 32'(in_count), 32'd0);
    chk("midrst_iv_during", 32'(Iout_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_empty", 32'(empty_count), 32'd16);
    $display("mid-operation reset occ=%0d", occupancy);
    q.delete();
    reset = 1'b1;
    step(4'b0001, 0, 1'b0, 1);
    chk("post_rst_occ", 32'(occupancy), 32'd1);
    step(4'b0000, 3, 1'b0, 0);
    chk("post_rst_drain", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
